// File: rtl/gate_dly_pkg.sv
// gate_dly_pkg: channel FSM encoding and default sizing shared by gate_delay_multi
package gate_dly_pkg;
    localparam int GDM_NCH = 4;
    localparam int GDM_N = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, HIGH = 2'd2, HOLD = 2'd3} gdm_state_e;
endpackage

// File: rtl/gate_dly_chan.sv
// gate_dly_chan: one trigger-to-gate channel; GDM_RETRIGGER_EN adds the Retrig input
module gate_dly_chan
    import gate_dly_pkg::*;
#(
    parameter int N = GDM_N
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Inp,
    input  logic         Pol,
    input  logic         En,
    input  logic [N-1:0] Delay,
    input  logic [N-1:0] Width,
`ifdef GDM_RETRIGGER_EN
    input  logic         Retrig,
`endif
    output logic         Q,
    output logic         Busy
);
    gdm_state_e state;
    logic s1, s2, s3, trig, go, done;
    logic [N-1:0] dcnt, wcnt, mcnt;
    assign trig = s2 & ~s3;
`ifdef GDM_RETRIGGER_EN
    assign go = En & trig & (state == IDLE || (Retrig && (state == DELAY || state == HIGH)));
`else
    assign go = En & trig & (state == IDLE);
`endif
    // follow mode closes the gate once its length catches up with the measured input
    assign done = (Width != '0) ? (wcnt == Width) : (wcnt == mcnt && !s2);
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            state <= IDLE;
            Q <= 1'b0;
            Busy <= 1'b0;
            dcnt <= '0;
            wcnt <= '0;
            mcnt <= '0;
        end else begin
            s1 <= Inp ^ Pol;
            s2 <= s1;
            s3 <= s2;
            if (go)
                mcnt <= N'(1);
            else if (state != IDLE && s2 && mcnt != '1)
                mcnt <= mcnt + N'(1);
            if (!En) begin
                state <= IDLE;
                Q <= 1'b0;
                Busy <= 1'b0;
            end else if (go) begin
                Busy <= 1'b1;
                if (Delay == '0) begin
                    state <= HIGH;
                    Q <= 1'b1;
                    wcnt <= N'(1);
                end else begin
                    state <= DELAY;
                    Q <= 1'b0;
                    dcnt <= Delay;
                end
            end else
                case (state)
                    IDLE: ;
                    DELAY:
                        if (dcnt == N'(1)) begin
                            state <= HIGH;
                            Q <= 1'b1;
                            wcnt <= N'(1);
                        end else
                            dcnt <= dcnt - N'(1);
                    HIGH:
                        if (done) begin
                            state <= HOLD;
                            Q <= 1'b0;
                        end else
                            wcnt <= wcnt + N'(1);
                    HOLD:
                        if (!s2) begin
                            state <= IDLE;
                            Busy <= 1'b0;
                        end
                endcase
        end
endmodule

// File: rtl/gate_delay_multi.sv
// gate_delay_multi: NCH independent trigger gate/delay channels; GDM_RETRIGGER_EN adds the Retrig port
module gate_delay_multi
    import gate_dly_pkg::*;
#(
    parameter int NCH = GDM_NCH,
    parameter int N = GDM_N
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NCH-1:0]   Inp,
    input  logic [NCH-1:0]   Pol,
    input  logic [NCH-1:0]   En,
    input  logic [NCH*N-1:0] Delay,
    input  logic [NCH*N-1:0] Width,
`ifdef GDM_RETRIGGER_EN
    input  logic [NCH-1:0]   Retrig,
`endif
    output logic [NCH-1:0]   Q,
    output logic [NCH-1:0]   Busy
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gate_dly_chan #(.N(N)) u_chan (
            .Clk(Clk),
            .Rst(Rst),
            .Inp(Inp[i]),
            .Pol(Pol[i]),
            .En(En[i]),
            .Delay(Delay[i*N +: N]),
            .Width(Width[i*N +: N]),
`ifdef GDM_RETRIGGER_EN
            .Retrig(Retrig[i]),
`endif
            .Q(Q[i]),
            .Busy(Busy[i])
        );
    end
endmodule
